// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: processor (p_*) and DMA (x_*) share one
// memory port, round-robin on ties, with a per-transaction mrdy timeout.
module dm_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        p_cs,
  input  logic        p_rd,
  input  logic        p_wr,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_rdy,
  output logic        p_err,
  output logic [31:0] p_rdata,
  input  logic        x_cs,
  input  logic        x_rd,
  input  logic        x_wr,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  output logic        x_rdy,
  output logic        x_err,
  output logic [31:0] x_rdata,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  input  logic        mrdy,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic [15:0] count;
  logic        p_req;
  logic        x_req;
  logic        any_req;
  logic        grant_x;
  logic        sel_wr;
  logic        timeout_hit;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    p_req       = p_cs & (p_rd | p_wr);
    x_req       = x_cs & (x_rd | x_wr);
    any_req     = p_req | x_req;
    grant_x     = x_req & (~p_req | ~last_grant);
    sel_wr      = grant_x ? x_wr : p_wr;
    timeout_hit = (count == LIMIT);
    state_next  = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mrdy || timeout_hit) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Every output is a flop; completion pulses default low each cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      p_rdy      <= 1'b0;
      p_err      <= 1'b0;
      p_rdata    <= '0;
      x_rdy      <= 1'b0;
      x_err      <= 1'b0;
      x_rdata    <= '0;
      dm_cs      <= 1'b0;
      dm_rd      <= 1'b0;
      dm_wr      <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      p_rdy <= 1'b0;
      p_err <= 1'b0;
      x_rdy <= 1'b0;
      x_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= grant_x;
            last_grant <= grant_x;
            busy       <= 1'b1;
            dm_cs      <= 1'b1;
            dm_wr      <= sel_wr;
            dm_rd      <= ~sel_wr;
            dm_addr    <= grant_x ? x_addr  : p_addr;
            dm_din     <= grant_x ? x_wdata : p_wdata;
            count      <= '0;
          end
        end
        BUSY: begin
          if (mrdy) begin
            dm_cs <= 1'b0;
            dm_rd <= 1'b0;
            dm_wr <= 1'b0;
            busy  <= 1'b0;
            if (owner) x_rdy <= 1'b1;
            else       p_rdy <= 1'b1;
            if (dm_rd) begin
              if (owner) x_rdata <= dm_dout;
              else       p_rdata <= dm_dout;
            end
          end else if (timeout_hit) begin
            dm_cs <= 1'b0;
            dm_rd <= 1'b0;
            dm_wr <= 1'b0;
            busy  <= 1'b0;
            if (owner) x_err <= 1'b1;
            else       p_err <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
